// File: rtl/alu_acc_ctrl.sv
// Sequential accumulator front-end for a combinational alu: takes commands over valid/ready,
// executes one alu step against the accumulator and returns acc/flags over valid/ready.
module alu_acc_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_load,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_operand,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_carry,
  output logic             out_zero,
  output logic [CNT_W-1:0] carry_cnt
);

  // state  | meaning
  // IDLE   | ready for a command
  // EXEC   | operands on alu, result written back at the edge
  // RESP   | response held until out_ready
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         sel_q, sel_d;
  logic               load_q, load_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      load_q  <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    sel_d   = sel_q;
    load_d  = load_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          b_d     = in_operand;
          sel_d   = in_op;
          load_d  = in_load;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (load_q) begin
          acc_d   = b_q;
          carry_d = 1'b0;
          zero_d  = (b_q == '0);
        end else begin
          acc_d   = alu_result;
          carry_d = alu_carryout;
          zero_d  = alu_zero;
          // counter sticks at all-ones instead of wrapping
          if (alu_carryout && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // gating with rst_n drops ready as soon as reset asserts, before any edge
  assign in_ready  = (state_q == S_IDLE) && rst_n;
  assign out_valid = (state_q == S_RESP);
  assign alu_a     = acc_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign out_acc   = acc_q;
  assign out_carry = carry_q;
  assign out_zero  = zero_q;
  assign carry_cnt = cnt_q;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Bench for alu_acc_ctrl: two instances (8-bit and 2-bit carry counters) share stimulus and
// are checked every cycle against a transaction-level accumulator model.
module tb_alu_acc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_load, out_ready;
  logic [2:0] in_op;
  logic [3:0] in_operand;

  logic       in_ready, out_valid, out_carry, out_zero;
  logic [3:0] alu_a, alu_b, out_acc, alu_result;
  logic [2:0] alu_sel;
  logic       alu_carryout, alu_zero;
  logic [7:0] carry_cnt;

  logic       in_ready_s, out_valid_s, out_carry_s, out_zero_s;
  logic [3:0] alu_a_s, alu_b_s, out_acc_s, alu_result_s;
  logic [2:0] alu_sel_s;
  logic       alu_carryout_s, alu_zero_s;
  logic [1:0] carry_cnt_s;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] acc;
    logic       c;
    logic       z;
    int         cnt;
  } resp_t;

  resp_t      q[$];
  logic [3:0] m_acc = 4'h0;
  int         m_cnt = 0;
  logic [3:0] committed = 4'h0;

  always #5 clk = ~clk;

  // reference alu: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 A+1, 111 A-1
  function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] s);
    case (s)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {1'b0, a} - {1'b0, b};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, ~a};
      3'd6: return {1'b0, a} + 5'd1;
      default: return {1'b0, a} - 5'd1;
    endcase
  endfunction

  assign {alu_carryout, alu_result}     = alu_fn(alu_a, alu_b, alu_sel);
  assign alu_zero                       = (alu_result == 4'h0);
  assign {alu_carryout_s, alu_result_s} = alu_fn(alu_a_s, alu_b_s, alu_sel_s);
  assign alu_zero_s                     = (alu_result_s == 4'h0);

  alu_acc_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load),
    .in_op(in_op), .in_operand(in_operand), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_carry(out_carry),
    .out_zero(out_zero), .carry_cnt(carry_cnt)
  );

  alu_acc_ctrl #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_load(in_load),
    .in_op(in_op), .in_operand(in_operand), .alu_a(alu_a_s), .alu_b(alu_b_s),
    .alu_sel(alu_sel_s), .alu_result(alu_result_s), .alu_carryout(alu_carryout_s),
    .alu_zero(alu_zero_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_acc(out_acc_s), .out_carry(out_carry_s), .out_zero(out_zero_s),
    .carry_cnt(carry_cnt_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // one response per accepted command; acc/flags/counters must match the model's entry
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready_sat_agree", in_ready_s, in_ready);
      if (q.size() == 0) begin
        chk("no_resp_out_valid", out_valid, 1'b0);
        chk("no_resp_out_valid_sat", out_valid_s, 1'b0);
        if (in_ready) chk("alu_a_is_acc", alu_a, committed);
      end else if (out_valid) begin
        chk("resp_acc", out_acc, q[0].acc);
        chk("resp_carry", out_carry, q[0].c);
        chk("resp_zero", out_zero, q[0].z);
        chk("resp_cnt8", carry_cnt, (q[0].cnt > 255) ? 255 : q[0].cnt);
        chk("resp_cnt2", carry_cnt_s, (q[0].cnt > 3) ? 3 : q[0].cnt);
        chk("resp_valid_sat", out_valid_s, 1'b1);
        chk("resp_acc_sat", out_acc_s, q[0].acc);
        if (out_ready) begin
          committed = q[0].acc;
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic model_apply(input logic ld, input logic [2:0] op, input logic [3:0] opd);
    resp_t r;
    logic [4:0] res;
    if (ld) begin
      m_acc = opd;
      r.c   = 1'b0;
    end else begin
      res   = alu_fn(m_acc, opd, op);
      m_acc = res[3:0];
      r.c   = res[4];
      if (res[4]) m_cnt++;
    end
    r.acc = m_acc;
    r.z   = (m_acc == 4'h0);
    r.cnt = m_cnt;
    q.push_back(r);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_in_ready_timeout", in_ready, 1'b1);
  endtask

  // lcnt < 0 skips the 2-bit counter literal
  task automatic issue(input logic ld, input logic [2:0] op, input logic [3:0] opd,
                       input bit lit, input logic [3:0] la, input logic lc, input logic lz,
                       input int lcnt);
    wait_ready();
    in_valid   = 1'b1;
    in_load    = ld;
    in_op      = op;
    in_operand = opd;
    @(posedge clk);
    model_apply(ld, op, opd);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("latency_exec_no_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("latency_resp_valid", out_valid, 1'b1);
    if (lit) begin
      chk("lit_acc", out_acc, la);
      chk("lit_carry", out_carry, lc);
      chk("lit_zero", out_zero, lz);
      if (lcnt >= 0) chk("lit_cnt2", carry_cnt_s, lcnt);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic cmd(input logic ld, input logic [2:0] op, input logic [3:0] opd,
                     input bit lit, input logic [3:0] la, input logic lc, input logic lz,
                     input int lcnt);
    issue(ld, op, opd, lit, la, lc, lz, lcnt);
    drain();
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    q.delete();
    m_acc     = 4'h0;
    m_cnt     = 0;
    committed = 4'h0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_op = 3'd0; in_operand = 4'h0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_acc", out_acc, 4'h0);
    chk("rst_cnt", carry_cnt, 8'h0);
    chk("rst_alu_b", alu_b, 4'h0);
    chk("rst_alu_sel", alu_sel, 3'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // 1: load 3, add 1
    cmd(1'b1, 3'b000, 4'h3, 1'b1, 4'h3, 1'b0, 1'b0, 0);
    cmd(1'b0, 3'b000, 4'h1, 1'b1, 4'h4, 1'b0, 1'b0, 0);

    // 2: load F, add 1 wraps with carry; then A+1
    cmd(1'b1, 3'b000, 4'hF, 1'b1, 4'hF, 1'b0, 1'b0, 0);
    cmd(1'b0, 3'b000, 4'h1, 1'b1, 4'h0, 1'b1, 1'b1, 1);
    cmd(1'b0, 3'b110, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0, 1);

    // 3: backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    issue(1'b0, 3'b000, 4'h2, 1'b1, 4'h3, 1'b0, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 in_valid = (i % 2 == 0); in_load = 1'b1; in_operand = 4'(i + 8);
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_acc", out_acc, 4'h3);
    end
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_idle", in_ready, 1'b1);
    chk("bp_release_no_valid", out_valid, 1'b0);

    // 4: chained logic ops
    cmd(1'b1, 3'b000, 4'h3, 1'b1, 4'h3, 1'b0, 1'b0, -1);
    cmd(1'b0, 3'b010, 4'h1, 1'b1, 4'h1, 1'b0, 1'b0, -1);
    cmd(1'b0, 3'b011, 4'h4, 1'b1, 4'h5, 1'b0, 1'b0, -1);
    cmd(1'b0, 3'b100, 4'h5, 1'b1, 4'h0, 1'b0, 1'b1, -1);
    cmd(1'b0, 3'b101, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, -1);
    cmd(1'b0, 3'b001, 4'h6, 1'b1, 4'h9, 1'b0, 1'b0, -1);
    cmd(1'b0, 3'b111, 4'h0, 1'b1, 4'h8, 1'b0, 1'b0, -1);
    cmd(1'b1, 3'b000, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, -1);

    // 5: 2-bit carry counter saturates at 3
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cmd(1'b1, 3'b000, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, -1);
      cmd(1'b0, 3'b000, 4'h1, 1'b1, 4'h0, 1'b1, 1'b1, (i < 3) ? i + 1 : 3);
    end
    chk("sat_cnt8_unsaturated", carry_cnt, 8'd4);
    cmd(1'b1, 3'b000, 4'hA, 1'b1, 4'hA, 1'b0, 1'b0, 3);

    // 6: async reset in EXEC discards the command
    wait_ready();
    in_valid = 1'b1; in_load = 1'b0; in_op = 3'b000; in_operand = 4'h1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_acc", out_acc, 4'h0);
    chk("mid_rst_cnt2", carry_cnt_s, 2'd0);
    q.delete();
    m_acc = 4'h0; m_cnt = 0; committed = 4'h0;
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    repeat (6) @(negedge clk);
    cmd(1'b0, 3'b110, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
